bloc_xfer_tx: RTL and testbench

- Transmit end of the block-transfer bus. The RAM-side receiver consumes `bloc_xfer` / `address` / `data_bus` for a fixed count of clock cycles.
- A host loads 16-bit words into an internal FIFO, then issues `start`.
- The block then drives exactly BURST_LEN consecutive words, with incrementing addresses, while holding `bloc_xfer` high.

---
 rtl/bloc_xfer_tx.sv | 144 ++++++++++++++
 tb/tb_bloc_xfer_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bloc_xfer_tx.sv
// Block-transfer transmitter: host FIFO plus fixed-length burst engine.
// Optional per-burst byte swap under `BLOC_XFER_TX_BYTE_SWAP_EN.
module bloc_xfer_tx #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 8,
  parameter int BURST_LEN = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          start_addr,
`ifdef BLOC_XFER_TX_BYTE_SWAP_EN
  input  logic                       swap,
`endif
  output logic                       start_err,
  output logic                       busy,
  output logic                       bloc_xfer,
  output logic [ADDR_W-1:0]          address,
  output logic [DATA_W-1:0]          data_bus,
  output logic                       done
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [LW-1:0]     level_nx;
  logic [LW-1:0]     beat;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] word;
  logic              push;
  logic              pop;
  logic              accept;
  logic              reject;
  logic              last;

  // full is registered, so a push is judged before any same-cycle pop
  assign push     = wr_en && !full;
  assign head     = mem[rd_ptr];
  assign last     = (beat == LW'(BURST_LEN - 1));
  assign level_nx = level + LW'(push) - LW'(pop);

`ifdef BLOC_XFER_TX_BYTE_SWAP_EN
  logic swap_q;
  assign word = swap_q ? {head[DATA_W/2-1:0], head[DATA_W-1:DATA_W/2]}
                       : head;
`else
  assign word = head;
`endif

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    accept   = 1'b0;
    reject   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (level >= LW'(BURST_LEN)) begin
            accept   = 1'b1;
            state_nx = XFER;
          end else begin
            reject = 1'b1;
          end
        end
      end
      XFER: begin
        pop = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_nx;
      full  <= (level_nx == LW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_err <= 1'b0;
      busy      <= 1'b0;
      bloc_xfer <= 1'b0;
      address   <= '0;
      data_bus  <= '0;
      done      <= 1'b0;
      beat      <= '0;
      base      <= '0;
`ifdef BLOC_XFER_TX_BYTE_SWAP_EN
      swap_q    <= 1'b0;
`endif
    end else begin
      start_err <= reject;
      done      <= (state == DONE);
      busy      <= (state_nx != IDLE);
      bloc_xfer <= pop;
      data_bus  <= pop ? word : '0;
      if (accept) begin
        base <= start_addr;
        beat <= '0;
`ifdef BLOC_XFER_TX_BYTE_SWAP_EN
        swap_q <= swap;
`endif
      end
      if (pop) begin
        address <= base + ADDR_W'(beat);
        beat    <= beat + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bloc_xfer_tx.sv
// Directed bench for bloc_xfer_tx: bursts, rejects, overflow, wrap, reset.
// Byte-swap steps run when BLOC_XFER_TX_BYTE_SWAP_EN is defined.
module tb_bloc_xfer_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        full;
  logic [3:0]  level;
  logic        start;
  logic [7:0]  start_addr;
  logic        start_err;
  logic        busy;
  logic        bloc_xfer;
  logic [7:0]  address;
  logic [15:0] data_bus;
  logic        done;
`ifdef BLOC_XFER_TX_BYTE_SWAP_EN
  logic        swap;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bloc_xfer_tx dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .level      (level),
    .start      (start),
    .start_addr (start_addr),
`ifdef BLOC_XFER_TX_BYTE_SWAP_EN
    .swap       (swap),
`endif
    .start_err  (start_err),
    .busy       (busy),
    .bloc_xfer  (bloc_xfer),
    .address    (address),
    .data_bus   (data_bus),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic go(input logic [7:0] a);
    start      = 1'b1;
    start_addr = a;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0;
    start = 1'b0; start_addr = '0;
`ifdef BLOC_XFER_TX_BYTE_SWAP_EN
    swap = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_level", level, 0);
    check("rst_full", full, 0);
    check("rst_bloc", bloc_xfer, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", address, 0);
    check("rst_data", data_bus, 0);
    check("rst_done", done, 0);
    check("rst_err", start_err, 0);

    // basic burst 1111..5555 at 0x10
    for (int i = 1; i <= 5; i++) push(16'(16'h1111 * i));
    check("b1_level", level, 5);
    go(8'h10);
    check("b1_busy", busy, 1);
    check("b1_pre", bloc_xfer, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b1_bloc", bloc_xfer, 1);
      check("b1_addr", address, 32'(8'h10 + i));
      check("b1_data", data_bus, 32'(16'h1111 * (i + 1)));
      check("b1_done_lo", done, 0);
    end
    @(negedge clk);
    check("b1_end_bloc", bloc_xfer, 0);
    check("b1_done", done, 1);
    check("b1_end_data", data_bus, 0);
    check("b1_hold_addr", address, 8'h14);
    check("b1_level0", level, 0);
    @(negedge clk);
    check("b1_done_pulse", done, 0);

    // rejected start with only 3 words
    for (int i = 0; i < 3; i++) push(16'hAAA0 + 16'(i));
    go(8'h40);
    check("rej_err", start_err, 1);
    check("rej_bloc", bloc_xfer, 0);
    check("rej_busy", busy, 0);
    check("rej_level", level, 3);
    @(negedge clk);
    check("rej_err_pulse", start_err, 0);
    check("rej_bloc2", bloc_xfer, 0);

    // overflow: 9 pushes, 9th dropped; burst wraps address at FE
    do_reset();
    for (int i = 1; i <= 8; i++) push(16'h0101 * 16'(i));
    check("ovf_full", full, 1);
    check("ovf_level8", level, 8);
    push(16'h0909);
    check("ovf_level_drop", level, 8);
    go(8'hFE);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("wrap_addr", address, 32'(8'(8'hFE + i)));
      check("wrap_data", data_bus, 32'(16'h0101 * (i + 1)));
    end
    @(negedge clk);
    check("wrap_level3", level, 3);
    check("wrap_full", full, 0);
    @(negedge clk);
    // remaining words must be 6,7,8 then the two new ones
    push(16'hBEE1);
    push(16'hBEE2);
    go(8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 3) check("left_data", data_bus, 32'(16'h0101 * (i + 6)));
      else       check("left_new", data_bus, 32'(16'hBEE1 + (i - 3)));
    end
    @(negedge clk);
    @(negedge clk);

    // reset on the 3rd beat
    for (int i = 0; i < 5; i++) push(16'hC000 + 16'(i));
    go(8'h20);
    @(negedge clk);
    @(negedge clk);
    check("mid_beat2", data_bus, 16'hC001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_bloc", bloc_xfer, 0);
    check("mid_data", data_bus, 0);
    check("mid_addr", address, 0);
    check("mid_busy", busy, 0);
    check("mid_level", level, 0);
    check("mid_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_no_done", done, 0);
      check("mid_no_bloc", bloc_xfer, 0);
    end
    go(8'h20);
    check("mid_start_err", start_err, 1);
    @(negedge clk);

    // push every beat: level holds at 5
    for (int i = 0; i < 5; i++) push(16'h1000 + 16'(i));
    go(8'h30);
    for (int i = 0; i < 5; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'h2000 + 16'(i);
      @(negedge clk);
      check("pp_data", data_bus, 32'(16'h1000 + i));
      check("pp_level", level, 5);
    end
    wr_en = 1'b0;
    @(negedge clk);
    check("pp_done", done, 1);
    check("pp_level_end", level, 5);
    go(8'h50);
    check("pp_restart_err", start_err, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("pp2_addr", address, 32'(8'h50 + i));
      check("pp2_data", data_bus, 32'(16'h2000 + i));
    end
    @(negedge clk);
    check("pp2_done", done, 1);
    @(negedge clk);

`ifdef BLOC_XFER_TX_BYTE_SWAP_EN
    do_reset();
    for (int i = 0; i < 5; i++) push(16'hA1B2);
    swap = 1'b1;
    go(8'h00);
    swap = 1'b0;
    @(negedge clk);
    check("swap1", data_bus, 16'hB2A1);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 5; i++) push(16'hA1B2);
    go(8'h00);
    @(negedge clk);
    check("swap0", data_bus, 16'hA1B2);
    repeat (5) @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
